// File: rtl/simple_pkg.sv
// Shared types and widths for the SIMPLE 5-stage core: datapath sizes, ALU
// opcodes and the control bundle carried through the ID/EX, EX/MEM and MEM/WB registers.
package simple_pkg;

  localparam int DATA_W  = 16;
  localparam int REG_AW  = 3;
  localparam int ALUOP_W = 4;
  localparam int CNT_W   = 16;

  typedef enum logic [ALUOP_W-1:0] {
    ALU_ADD   = 4'd0,
    ALU_SUB   = 4'd1,
    ALU_AND   = 4'd2,
    ALU_OR    = 4'd3,
    ALU_XOR   = 4'd4,
    ALU_SLT   = 4'd5,
    ALU_SLL   = 4'd6,
    ALU_SRL   = 4'd7,
    ALU_PASSB = 4'd8
  } alu_op_e;

  typedef struct packed {
    logic               regwrite;
    logic               memread;
    logic               memwrite;
    logic               alusrc;
    logic [ALUOP_W-1:0] aluop;
  } ctrl_t;

  typedef struct packed {
    logic              valid;
    logic [REG_AW-1:0] ra;
    logic [REG_AW-1:0] rb;
    logic [REG_AW-1:0] rd;
    logic [DATA_W-1:0] rdataA;
    logic [DATA_W-1:0] rdataB;
    logic [DATA_W-1:0] imm;
    ctrl_t             ctrl;
  } idExT;

  localparam idExT ID_EX_BUBBLE = '0;

  // Strip every side effect so a non-instruction can never write state or forward.
  function automatic ctrl_t killCtrl(input ctrl_t c);
    ctrl_t k;
    k          = c;
    k.regwrite = 1'b0;
    k.memread  = 1'b0;
    k.memwrite = 1'b0;
    return k;
  endfunction

endpackage

// File: rtl/id_ex_stage_if.sv
// ID-side inputs and EX-side outputs of the ID/EX register; master drives ID,
// slave is the pipeline register itself.
interface id_ex_stage_if;
  import simple_pkg::*;

  logic               hold;
  logic               flush;
  logic               id_valid;
  logic [REG_AW-1:0]  id_ra;
  logic [REG_AW-1:0]  id_rb;
  logic [REG_AW-1:0]  id_rd;
  logic               id_use_ra;
  logic               id_use_rb;
  logic [DATA_W-1:0]  id_rdata_a;
  logic [DATA_W-1:0]  id_rdata_b;
  logic [DATA_W-1:0]  id_imm;
  logic               id_regwrite;
  logic               id_memread;
  logic               id_memwrite;
  logic               id_alusrc;
  logic [ALUOP_W-1:0] id_aluop;

  logic               load_use_stall;
  logic               ex_valid;
  logic [REG_AW-1:0]  ex_ra;
  logic [REG_AW-1:0]  ex_rb;
  logic [REG_AW-1:0]  ex_rd;
  logic [DATA_W-1:0]  ex_rdata_a;
  logic [DATA_W-1:0]  ex_rdata_b;
  logic [DATA_W-1:0]  ex_imm;
  logic               ex_regwrite;
  logic               ex_memread;
  logic               ex_memwrite;
  logic               ex_alusrc;
  logic [ALUOP_W-1:0] ex_aluop;
  logic [CNT_W-1:0]   bubble_cnt;

  modport master (
    output hold, flush, id_valid, id_ra, id_rb, id_rd, id_use_ra, id_use_rb,
           id_rdata_a, id_rdata_b, id_imm, id_regwrite, id_memread,
           id_memwrite, id_alusrc, id_aluop,
    input  load_use_stall, ex_valid, ex_ra, ex_rb, ex_rd, ex_rdata_a,
           ex_rdata_b, ex_imm, ex_regwrite, ex_memread, ex_memwrite,
           ex_alusrc, ex_aluop, bubble_cnt
  );

  modport slave (
    input  hold, flush, id_valid, id_ra, id_rb, id_rd, id_use_ra, id_use_rb,
           id_rdata_a, id_rdata_b, id_imm, id_regwrite, id_memread,
           id_memwrite, id_alusrc, id_aluop,
    output load_use_stall, ex_valid, ex_ra, ex_rb, ex_rd, ex_rdata_a,
           ex_rdata_b, ex_imm, ex_regwrite, ex_memread, ex_memwrite,
           ex_alusrc, ex_aluop, bubble_cnt
  );

endinterface

// File: rtl/load_use_detect.sv
// Combinational load-use hazard compare: a load in EX whose destination is
// read by the valid instruction in ID.
module load_use_detect
  import simple_pkg::*;
(
  input  logic              exValid,
  input  logic              exMemread,
  input  logic              exRegwrite,
  input  logic [REG_AW-1:0] exRd,
  input  logic              idValid,
  input  logic [REG_AW-1:0] idRa,
  input  logic [REG_AW-1:0] idRb,
  input  logic              idUseRa,
  input  logic              idUseRb,
  output logic              stall
);

  logic loadInEx;
  logic raHit;
  logic rbHit;

  assign loadInEx = exValid & exMemread & exRegwrite;
  assign raHit    = idUseRa & (idRa == exRd);
  assign rbHit    = idUseRb & (idRb == exRd);
  assign stall    = loadInEx & idValid & (raHit | rbHit);

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use interlock and a saturating count of
// inserted bubbles (flush or stall).
module id_ex_stage
  import simple_pkg::*;
(
  input logic          clk,
  input logic          rst_n,
  id_ex_stage_if.slave bus
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  idExT             exQ;
  idExT             idIn;
  ctrl_t            idCtrl;
  logic             stall;
  logic             loadBubble;
  logic [CNT_W-1:0] bubbleCnt;

  // NOTE: every variable assigned in always_comb gets a default first so no latch can be inferred.
  always_comb begin
    idCtrl          = '0;
    idCtrl.regwrite = bus.id_regwrite;
    idCtrl.memread  = bus.id_memread;
    idCtrl.memwrite = bus.id_memwrite;
    idCtrl.alusrc   = bus.id_alusrc;
    idCtrl.aluop    = bus.id_aluop;

    idIn        = ID_EX_BUBBLE;
    idIn.valid  = bus.id_valid;
    idIn.ra     = bus.id_ra;
    idIn.rb     = bus.id_rb;
    idIn.rd     = bus.id_rd;
    idIn.rdataA = bus.id_rdata_a;
    idIn.rdataB = bus.id_rdata_b;
    idIn.imm    = bus.id_imm;
    idIn.ctrl   = bus.id_valid ? idCtrl : killCtrl(idCtrl);
  end

  load_use_detect u_detect (
    .exValid    (exQ.valid),
    .exMemread  (exQ.ctrl.memread),
    .exRegwrite (exQ.ctrl.regwrite),
    .exRd       (exQ.rd),
    .idValid    (bus.id_valid),
    .idRa       (bus.id_ra),
    .idRb       (bus.id_rb),
    .idUseRa    (bus.id_use_ra),
    .idUseRb    (bus.id_use_rb),
    .stall      (stall)
  );

  // Flush and stall together still collapse into a single bubble.
  assign loadBubble = bus.flush | stall;

  // NOTE: state registers update with non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      exQ       <= ID_EX_BUBBLE;
      bubbleCnt <= '0;
    end else if (!bus.hold) begin
      if (loadBubble) begin
        exQ <= ID_EX_BUBBLE;
        if (bubbleCnt != CNT_MAX) bubbleCnt <= bubbleCnt + 1'b1;
      end else begin
        exQ <= idIn;
      end
    end
  end

  assign bus.load_use_stall = stall;
  assign bus.ex_valid       = exQ.valid;
  assign bus.ex_ra          = exQ.ra;
  assign bus.ex_rb          = exQ.rb;
  assign bus.ex_rd          = exQ.rd;
  assign bus.ex_rdata_a     = exQ.rdataA;
  assign bus.ex_rdata_b     = exQ.rdataB;
  assign bus.ex_imm         = exQ.imm;
  assign bus.ex_regwrite    = exQ.ctrl.regwrite;
  assign bus.ex_memread     = exQ.ctrl.memread;
  assign bus.ex_memwrite    = exQ.ctrl.memwrite;
  assign bus.ex_alusrc      = exQ.ctrl.alusrc;
  assign bus.ex_aluop       = exQ.ctrl.aluop;
  assign bus.bubble_cnt     = bubbleCnt;

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed bench for id_ex_stage: a scoreboard holds expected EX contents and a
// monitor compares them whenever a fresh valid instruction appears in EX.
module tb_id_ex_stage;
  import simple_pkg::*;

  typedef struct packed {
    logic        valid;
    logic [2:0]  ra;
    logic [2:0]  rb;
    logic [2:0]  rd;
    logic [15:0] a;
    logic [15:0] b;
    logic [15:0] imm;
    logic        rw;
    logic        mr;
    logic        mw;
    logic        as;
    logic [3:0]  op;
  } expT;

  logic          clk;
  logic          rst_n;
  int            checks;
  int            errors;
  int            expBubbles;
  expT           expQ[$];

  id_ex_stage_if bus ();

  id_ex_stage dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [79:0] act, input logic [79:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic setInstr(input logic v, input logic [2:0] ra, input logic [2:0] rb,
                          input logic [2:0] rd, input logic ua, input logic ub,
                          input logic [15:0] a, input logic [15:0] b, input logic [15:0] imm,
                          input logic rw, input logic mr, input logic mw, input logic as,
                          input logic [3:0] op);
    bus.id_valid    = v;
    bus.id_ra       = ra;
    bus.id_rb       = rb;
    bus.id_rd       = rd;
    bus.id_use_ra   = ua;
    bus.id_use_rb   = ub;
    bus.id_rdata_a  = a;
    bus.id_rdata_b  = b;
    bus.id_imm      = imm;
    bus.id_regwrite = rw;
    bus.id_memread  = mr;
    bus.id_memwrite = mw;
    bus.id_alusrc   = as;
    bus.id_aluop    = op;
  endtask

  task automatic pushExp();
    expT e;
    e = '{valid: 1'b1, ra: bus.id_ra, rb: bus.id_rb, rd: bus.id_rd,
          a: bus.id_rdata_a, b: bus.id_rdata_b, imm: bus.id_imm,
          rw: bus.id_regwrite, mr: bus.id_memread, mw: bus.id_memwrite,
          as: bus.id_alusrc, op: bus.id_aluop};
    expQ.push_back(e);
  endtask

  task automatic checkBubble(input string tag);
    check({tag, "_ex_valid"},    80'(bus.ex_valid),    80'(0));
    check({tag, "_ex_regwrite"}, 80'(bus.ex_regwrite), 80'(0));
    check({tag, "_ex_memread"},  80'(bus.ex_memread),  80'(0));
    check({tag, "_bubble_cnt"},  80'(bus.bubble_cnt),  80'(expBubbles));
  endtask

  // Issue the instruction currently on the ID inputs; a hazard costs exactly one bubble.
  task automatic issue(input logic expStall, input string tag);
    #1;
    check({tag, "_stall"}, 80'(bus.load_use_stall), 80'(expStall));
    if (expStall) begin
      step();
      expBubbles++;
      checkBubble(tag);
      check({tag, "_stall_after"}, 80'(bus.load_use_stall), 80'(0));
    end
    pushExp();
    step();
  endtask

  initial begin : monitor
    logic heldEdge;
    expT  act;
    expT  e;
    forever begin
      @(posedge clk);
      heldEdge = bus.hold;
      @(negedge clk);
      if (!heldEdge && rst_n && bus.ex_valid) begin
        act = '{valid: bus.ex_valid, ra: bus.ex_ra, rb: bus.ex_rb, rd: bus.ex_rd,
                a: bus.ex_rdata_a, b: bus.ex_rdata_b, imm: bus.ex_imm,
                rw: bus.ex_regwrite, mr: bus.ex_memread, mw: bus.ex_memwrite,
                as: bus.ex_alusrc, op: bus.ex_aluop};
        if (expQ.size() == 0) begin
          check("sb_unexpected_ex", 80'(act), 80'(0));
        end else begin
          e = expQ.pop_front();
          check("ex_fields", 80'(act), 80'(e));
        end
      end
    end
  end

  initial begin
    checks     = 0;
    errors     = 0;
    expBubbles = 0;
    rst_n      = 1'b0;
    bus.hold   = 1'b0;
    bus.flush  = 1'b0;
    setInstr(0, 0, 0, 0, 0, 0, 16'h0, 16'h0, 16'h0, 0, 0, 0, 0, 4'h0);

    #1;
    check("rst_ex_valid",   80'(bus.ex_valid),       80'(0));
    check("rst_ex_memread", 80'(bus.ex_memread),     80'(0));
    check("rst_bubble_cnt", 80'(bus.bubble_cnt),     80'(0));
    check("rst_stall",      80'(bus.load_use_stall), 80'(0));
    #1 rst_n = 1'b1;

    // Pass-through
    setInstr(1, 3'd3, 3'd5, 3'd2, 1, 1, 16'h1234, 16'h00AB, 16'h0007, 1, 0, 0, 1, ALU_OR);
    issue(0, "pass");
    check("pass_ex_ra",     80'(bus.ex_ra),      80'(3));
    check("pass_ex_rb",     80'(bus.ex_rb),      80'(5));
    check("pass_ex_rd",     80'(bus.ex_rd),      80'(2));
    check("pass_ex_rdataa", 80'(bus.ex_rdata_a), 80'(16'h1234));
    check("pass_ex_valid",  80'(bus.ex_valid),   80'(1));

    // Load r4, then ADD reading r4 through Rb
    setInstr(1, 3'd1, 3'd0, 3'd4, 1, 0, 16'h0100, 16'h0, 16'h0010, 1, 1, 0, 1, ALU_ADD);
    issue(0, "ld_r4");
    setInstr(1, 3'd2, 3'd4, 3'd5, 1, 1, 16'h0011, 16'h0022, 16'h0, 1, 0, 0, 0, ALU_ADD);
    issue(1, "lu_rb");
    check("lu_cnt_after", 80'(bus.bubble_cnt), 80'(1));

    // Rb matches the load but is not read
    setInstr(1, 3'd1, 3'd0, 3'd4, 1, 0, 16'h0200, 16'h0, 16'h0004, 1, 1, 0, 1, ALU_ADD);
    issue(0, "ld_r4b");
    setInstr(1, 3'd1, 3'd4, 3'd6, 1, 0, 16'h0033, 16'h0044, 16'h0005, 1, 0, 0, 1, ALU_SUB);
    issue(0, "nonuse");

    // Both sources match the load destination
    setInstr(1, 3'd0, 3'd0, 3'd3, 1, 0, 16'h0300, 16'h0, 16'h0002, 1, 1, 0, 1, ALU_ADD);
    issue(0, "ld_r3");
    setInstr(1, 3'd3, 3'd3, 3'd7, 1, 1, 16'h0055, 16'h0066, 16'h0, 1, 0, 0, 0, ALU_XOR);
    issue(1, "both");

    // Invalid ID: control passes, side effects forced off, no bubble counted
    setInstr(0, 3'd1, 3'd2, 3'd3, 0, 0, 16'h0, 16'h0, 16'h0, 1, 1, 1, 1, ALU_SLT);
    #1;
    check("inv_stall", 80'(bus.load_use_stall), 80'(0));
    step();
    check("inv_ex_valid",    80'(bus.ex_valid),    80'(0));
    check("inv_ex_regwrite", 80'(bus.ex_regwrite), 80'(0));
    check("inv_ex_memwrite", 80'(bus.ex_memwrite), 80'(0));
    check("inv_ex_alusrc",   80'(bus.ex_alusrc),   80'(1));
    check("inv_ex_aluop",    80'(bus.ex_aluop),    80'(ALU_SLT));
    check("inv_bubble_cnt",  80'(bus.bubble_cnt),  80'(2));

    // Flush coinciding with a load-use stall
    setInstr(1, 3'd0, 3'd0, 3'd1, 0, 0, 16'h0400, 16'h0, 16'h0001, 1, 1, 0, 1, ALU_ADD);
    issue(0, "ld_r1");
    setInstr(1, 3'd1, 3'd2, 3'd5, 1, 0, 16'h0077, 16'h0, 16'h0, 1, 0, 0, 0, ALU_AND);
    bus.flush = 1'b1;
    #1;
    check("fs_stall", 80'(bus.load_use_stall), 80'(1));
    step();
    bus.flush = 1'b0;
    expBubbles++;
    checkBubble("fs");
    setInstr(1, 3'd0, 3'd0, 3'd3, 0, 0, 16'h0088, 16'h0099, 16'h0, 1, 0, 0, 0, ALU_SLL);
    issue(0, "after_flush");

    // Hold for three cycles over a pending stall
    setInstr(1, 3'd0, 3'd0, 3'd7, 0, 0, 16'h0500, 16'h0, 16'h0003, 1, 1, 0, 1, ALU_ADD);
    issue(0, "ld_r7");
    setInstr(1, 3'd2, 3'd7, 3'd4, 0, 1, 16'h00AA, 16'h00BB, 16'h0, 1, 0, 0, 0, ALU_SRL);
    bus.hold = 1'b1;
    #1;
    check("hold_stall_pre", 80'(bus.load_use_stall), 80'(1));
    for (int i = 0; i < 3; i++) begin
      step();
      check("hold_ex_rd",      80'(bus.ex_rd),          80'(7));
      check("hold_ex_memread", 80'(bus.ex_memread),     80'(1));
      check("hold_bubble_cnt", 80'(bus.bubble_cnt),     80'(expBubbles));
      check("hold_stall",      80'(bus.load_use_stall), 80'(1));
    end
    bus.hold = 1'b0;
    issue(1, "hold_rel");

    // Asynchronous reset mid-cycle with a load in EX
    setInstr(1, 3'd0, 3'd0, 3'd4, 0, 0, 16'h0600, 16'h0, 16'h0008, 1, 1, 0, 1, ALU_ADD);
    issue(0, "ld_pre_rst");
    #6;
    setInstr(1, 3'd4, 3'd0, 3'd2, 1, 0, 16'h00CC, 16'h0, 16'h0, 1, 0, 0, 0, ALU_ADD);
    rst_n = 1'b0;
    #1;
    check("mrst_ex_valid",   80'(bus.ex_valid),       80'(0));
    check("mrst_ex_memread", 80'(bus.ex_memread),     80'(0));
    check("mrst_ex_rd",      80'(bus.ex_rd),          80'(0));
    check("mrst_ex_rdataa",  80'(bus.ex_rdata_a),     80'(0));
    check("mrst_bubble_cnt", 80'(bus.bubble_cnt),     80'(0));
    check("mrst_stall",      80'(bus.load_use_stall), 80'(0));
    expBubbles = 0;
    rst_n = 1'b1;
    issue(0, "post_rst");

    // Counter saturation
    bus.flush = 1'b1;
    repeat (65534) step();
    check("sat_fffe", 80'(bus.bubble_cnt), 80'(16'hFFFE));
    for (int i = 0; i < 3; i++) begin
      step();
      check("sat_ffff", 80'(bus.bubble_cnt), 80'(16'hFFFF));
    end
    setInstr(0, 0, 0, 0, 0, 0, 16'h0, 16'h0, 16'h0, 0, 0, 0, 0, 4'h0);
    bus.flush = 1'b0;
    repeat (3) step();
    check("sb_drain", 80'(expQ.size()), 80'(0));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
